// File: rtl/keyed_decoder.sv
// Key-code decoder: synchronizes and debounces an active-low key vector, then drives
// a one-hot, thermometer, scanning or held pattern on active-low outputs.
`timescale 1ns/1ps
module keyed_decoder #(
    parameter int W        = 3,
    parameter int DEBOUNCE = 50000,
    parameter int SCAN_DIV = 5000000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [W-1:0]      in_n,
    input  logic [1:0]        mode,
    output logic [2**W-1:0]   out_n,
    output logic              change_p,
    output logic              vcc_for_keys
);
    localparam int N     = 2**W;
    localparam int CNT_W = $clog2(DEBOUNCE);
    localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE - 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

    typedef enum logic [1:0] {
        MODE_ONEHOT = 2'b00,
        MODE_THERM  = 2'b01,
        MODE_SCAN   = 2'b10,
        MODE_HOLD   = 2'b11
    } mode_e;

    logic [W-1:0]     in_s1, in_s2;
    logic [1:0]       mode_s1, mode_s2;
    mode_e            mode_cur, mode_prev;
    logic [W-1:0]     sync_in;

    logic [W-1:0]     cand, cand_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [W-1:0]     code, code_nxt;

    logic [W-1:0]     scan_idx, scan_nxt;
    logic [DIV_W-1:0] div, div_nxt;
    logic             scan_entry;

    logic [N-1:0]     out, out_nxt, out_prev;

    assign sync_in  = ~in_s2;
    assign mode_cur = mode_e'(mode_s2);

    // Debounce: a value must be seen unchanged for DEBOUNCE+1 samples to be accepted.
    always_comb begin
        cand_nxt = cand;
        cnt_nxt  = cnt;
        code_nxt = code;
        if (sync_in != cand) begin
            cand_nxt = sync_in;
            cnt_nxt  = '0;
        end else if (cnt != CNT_LAST) begin
            cnt_nxt = cnt + CNT_W'(1);
        end else begin
            code_nxt = cand;
        end
    end

    // Entering scan restarts from the current code so the first step shows it immediately.
    always_comb begin
        scan_entry = (mode_cur == MODE_SCAN) && (mode_prev != MODE_SCAN);
        scan_nxt   = scan_idx;
        div_nxt    = div;
        if (scan_entry) begin
            scan_nxt = code;
            div_nxt  = '0;
        end else if (mode_cur == MODE_SCAN) begin
            if (div == DIV_LAST) begin
                div_nxt  = '0;
                scan_nxt = scan_idx + W'(1);
            end else begin
                div_nxt = div + DIV_W'(1);
            end
        end
    end

    // The pattern uses the code registered before this edge; a code accepted on the
    // same edge shows up one cycle later.
    always_comb begin
        out_nxt = out;
        case (mode_cur)
            MODE_ONEHOT: out_nxt = N'(1) << code;
            MODE_THERM: begin
                for (int i = 0; i < N; i++) begin
                    out_nxt[i] = (W'(i) <= code);
                end
            end
            MODE_SCAN:   out_nxt = N'(1) << scan_nxt;
            MODE_HOLD:   out_nxt = out;
            default:     out_nxt = out;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_s1     <= '0;
            in_s2     <= '0;
            mode_s1   <= '0;
            mode_s2   <= '0;
            mode_prev <= MODE_ONEHOT;
            cand      <= '0;
            cnt       <= '0;
            code      <= '0;
            scan_idx  <= '0;
            div       <= '0;
            out       <= '0;
            out_prev  <= '0;
            change_p  <= 1'b0;
        end else begin
            in_s1     <= in_n;
            in_s2     <= in_s1;
            mode_s1   <= mode;
            mode_s2   <= mode_s1;
            mode_prev <= mode_cur;
            cand      <= cand_nxt;
            cnt       <= cnt_nxt;
            code      <= code_nxt;
            scan_idx  <= scan_nxt;
            div       <= div_nxt;
            out       <= out_nxt;
            out_prev  <= out;
            change_p  <= (out != out_prev);
        end
    end

    assign out_n        = ~out;
    assign vcc_for_keys = 1'b1;

endmodule

// File: tb/tb_keyed_decoder.sv
// Bench for keyed_decoder: directed scenarios plus random key/mode traffic, each cycle
// compared against a behavioural model built from run lengths and elapsed scan time.
`timescale 1ns/1ps
module tb_keyed_decoder;
    localparam int W    = 3;
    localparam int DEB  = 4;
    localparam int SDIV = 3;
    localparam int N    = 8;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic [2:0] in_n  = 3'b111;
    logic [1:0] mode  = 2'b00;
    logic [7:0] out_n;
    logic       change_p;
    logic       vcc_for_keys;

    keyed_decoder #(.W(W), .DEBOUNCE(DEB), .SCAN_DIV(SDIV)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_n         (in_n),
        .mode         (mode),
        .out_n        (out_n),
        .change_p     (change_p),
        .vcc_for_keys (vcc_for_keys)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int pulses   = 0;

    // reference model state
    logic [2:0] m_in_d1, m_in_d2;
    logic [1:0] m_mode_d1, m_mode_d2, m_prev_mode;
    int         m_run;
    logic [2:0] m_run_val, m_code, m_scan_base;
    int         m_scan_j;
    logic [7:0] m_out, m_out_prev;
    logic       m_chg;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    task automatic model_reset();
        m_in_d1 = '0; m_in_d2 = '0;
        m_mode_d1 = '0; m_mode_d2 = '0; m_prev_mode = '0;
        m_run = 1; m_run_val = '0; m_code = '0;
        m_scan_base = '0; m_scan_j = 0;
        m_out = '0; m_out_prev = '0; m_chg = 1'b0;
    endtask

    // One rising edge: inputs still hold the values that were present before the edge.
    task automatic model_step();
        logic [2:0] s_in;
        logic [1:0] s_mode;
        logic [2:0] old_code;
        logic [7:0] nout;
        int         idx;
        if (!rst_n) begin
            model_reset();
            return;
        end
        s_in   = ~m_in_d2;
        s_mode = m_mode_d2;
        m_in_d2 = m_in_d1;  m_in_d1 = in_n;
        m_mode_d2 = m_mode_d1; m_mode_d1 = mode;
        old_code = m_code;
        if (s_in == m_run_val) begin
            if (m_run < 1000) m_run++;
        end else begin
            m_run_val = s_in;
            m_run = 1;
        end
        if (m_run >= DEB + 1) m_code = m_run_val;
        if (s_mode == 2'b10) begin
            if (m_prev_mode != 2'b10) begin
                m_scan_base = old_code;
                m_scan_j = 0;
            end else begin
                m_scan_j++;
            end
        end
        case (s_mode)
            2'b00: nout = 8'(1 << old_code);
            2'b01: nout = 8'((2 << old_code) - 1);
            2'b10: begin
                idx  = (int'(m_scan_base) + m_scan_j / SDIV) % N;
                nout = 8'(1 << idx);
            end
            default: nout = m_out;
        endcase
        m_chg = (m_out != m_out_prev);
        m_out_prev = m_out;
        m_out = nout;
        m_prev_mode = s_mode;
    endtask

    task automatic cycle();
        logic [7:0] exp_n;
        @(posedge clk);
        model_step();
        @(negedge clk);
        exp_n = ~m_out;
        check_val("out_n", 32'(out_n), 32'(exp_n));
        check_val("change_p", 32'(change_p), 32'(m_chg));
        if (change_p) pulses++;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic async_reset(input int hold);
        #2 rst_n = 1'b0;
        #1;
        check_val("arst_out_n", 32'(out_n), 32'hFF);
        check_val("arst_change_p", 32'(change_p), 32'h0);
        model_reset();
        run(hold);
        rst_n = 1'b1;
    endtask

    initial begin
        model_reset();
        run(3);
        check_val("rst_out_n", 32'(out_n), 32'hFF);
        check_val("vcc", 32'(vcc_for_keys), 32'h1);

        // release, keys up, one-hot
        rst_n = 1'b1; pulses = 0;
        run(12);
        check_val("rel_out_n", 32'(out_n), 32'hFE);
        check_val("rel_pulses", 32'(pulses), 32'd1);

        // code 5 with exact latency
        in_n = 3'b010; pulses = 0;
        run(7);
        check_val("lat_before", 32'(out_n), 32'hFE);
        run(1);
        check_val("lat_at", 32'(out_n), 32'hDF);
        run(4);
        check_val("code5_pulses", 32'(pulses), 32'd1);

        // three-cycle glitch to code 6
        pulses = 0; in_n = 3'b001;
        run(3);
        in_n = 3'b010;
        run(10);
        check_val("glitch_out_n", 32'(out_n), 32'hDF);
        check_val("glitch_pulses", 32'(pulses), 32'd0);

        // thermometer
        mode = 2'b01; in_n = 3'b101; run(12);
        check_val("therm2", 32'(out_n), 32'hF8);
        in_n = 3'b000; run(12);
        check_val("therm7", 32'(out_n), 32'h00);
        in_n = 3'b111; run(12);
        check_val("therm0", 32'(out_n), 32'hFE);

        // scan from code 6, wrap, hold, then back to one-hot
        in_n = 3'b001; run(12);
        mode = 2'b10; run(3);
        check_val("scan6", 32'(out_n), 32'hBF);
        run(3);
        check_val("scan7", 32'(out_n), 32'h7F);
        run(3);
        check_val("scan0", 32'(out_n), 32'hFE);
        run(3);
        mode = 2'b11; run(3);
        check_val("hold_enter", 32'(out_n), 32'hFD);
        in_n = 3'b100; run(12);
        check_val("hold_keys", 32'(out_n), 32'hFD);
        mode = 2'b00; run(4);
        check_val("hold_exit", 32'(out_n), 32'hF7);

        // reset mid-scan and mid-debounce
        mode = 2'b10; run(6);
        in_n = 3'b110; run(2);
        async_reset(3);
        in_n = 3'b111; mode = 2'b00; pulses = 0;
        run(12);
        check_val("rerel_out_n", 32'(out_n), 32'hFE);
        check_val("rerel_pulses", 32'(pulses), 32'd1);

        // random traffic
        for (int seg = 0; seg < 200; seg++) begin
            in_n = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 3) == 0) mode = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 39) == 0) async_reset($urandom_range(1, 3));
            run($urandom_range(1, 8));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
